// File: rtl/adc_scan_sequencer.sv
// Masked round-robin frame scanner driving one shared single-slope ADC handler.
// Each enabled channel is cleared, converted (with timeout) and reported as a tagged sample.
module adc_scan_sequencer #(
    parameter int NCH        = 4,
    parameter int DW         = 8,
    parameter int TIMEOUT    = 300,
    parameter int CLR_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NCH-1:0]           chan_mask,
    input  logic                     adc_done,
    input  logic [DW-1:0]            adc_data,
    output logic                     adc_enable,
    output logic                     adc_clear,
    output logic [$clog2(NCH)-1:0]   ch_sel,
    output logic [DW-1:0]            sample_data,
    output logic [$clog2(NCH)-1:0]   sample_ch,
    output logic                     sample_valid,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     timeout_err
);

    localparam int CW = $clog2(NCH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int KW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_CONVERT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [NCH-1:0]  mask_q, mask_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [KW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            adc_enable_q, adc_enable_d;
    logic            adc_clear_q, adc_clear_d;
    logic [CW-1:0]   ch_sel_q, ch_sel_d;
    logic [DW-1:0]   sample_data_q, sample_data_d;
    logic [CW-1:0]   sample_ch_q, sample_ch_d;
    logic            sample_valid_q, sample_valid_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;
    logic            timeout_err_q, timeout_err_d;

    // Returns {found, index} of the lowest set bit of m at or above position lo.
    function automatic logic [CW:0] find_from(input logic [NCH-1:0] m, input int lo);
        logic [CW:0] hit;
        hit = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i >= lo && m[i]) begin
                hit = {1'b1, CW'(i)};
            end
        end
        return hit;
    endfunction

    logic [CW:0] first_hit;
    logic [CW:0] next_hit;
    logic        clr_last;
    logic        cap_done;
    logic        cap_to;
    logic        capture;

    always_comb begin
        first_hit = find_from(chan_mask, 0);
        next_hit  = find_from(mask_q, int'(ch_sel_q) + 1);
        clr_last  = (clr_cnt_q == KW'(CLR_CYCLES - 1));
        cap_done  = (state_q == S_CONVERT) && adc_done;
        // A done arriving on the timeout edge takes priority, so no error in that case.
        cap_to    = (state_q == S_CONVERT) && !adc_done && (timer_q == TW'(TIMEOUT - 1));
        capture   = cap_done || cap_to;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (chan_mask == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (clr_last) begin
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (capture) begin
                    state_d = next_hit[CW] ? S_CLEAR : S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mask_d         = mask_q;
        timer_d        = timer_q;
        clr_cnt_d      = clr_cnt_q;
        adc_enable_d   = adc_enable_q;
        adc_clear_d    = adc_clear_q;
        ch_sel_d       = ch_sel_q;
        sample_data_d  = sample_data_q;
        sample_ch_d    = sample_ch_q;
        sample_valid_d = 1'b0;
        busy_d         = busy_q;
        frame_done_d   = 1'b0;
        timeout_err_d  = timeout_err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d        = chan_mask;
                    timeout_err_d = 1'b0;
                    busy_d        = 1'b1;
                    if (first_hit[CW]) begin
                        ch_sel_d    = first_hit[CW-1:0];
                        adc_clear_d = 1'b1;
                        clr_cnt_d   = '0;
                    end else begin
                        frame_done_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_last) begin
                    adc_clear_d  = 1'b0;
                    adc_enable_d = 1'b1;
                    timer_d      = '0;
                end
            end
            S_CONVERT: begin
                timer_d = timer_q + 1'b1;
                if (capture) begin
                    sample_valid_d = 1'b1;
                    sample_ch_d    = ch_sel_q;
                    sample_data_d  = cap_done ? adc_data : '1;
                    adc_enable_d   = 1'b0;
                    if (cap_to) begin
                        timeout_err_d = 1'b1;
                    end
                    if (next_hit[CW]) begin
                        ch_sel_d    = next_hit[CW-1:0];
                        adc_clear_d = 1'b1;
                        clr_cnt_d   = '0;
                    end else begin
                        frame_done_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mask_q         <= '0;
            timer_q        <= '0;
            clr_cnt_q      <= '0;
            adc_enable_q   <= 1'b0;
            adc_clear_q    <= 1'b0;
            ch_sel_q       <= '0;
            sample_data_q  <= '0;
            sample_ch_q    <= '0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            mask_q         <= mask_d;
            timer_q        <= timer_d;
            clr_cnt_q      <= clr_cnt_d;
            adc_enable_q   <= adc_enable_d;
            adc_clear_q    <= adc_clear_d;
            ch_sel_q       <= ch_sel_d;
            sample_data_q  <= sample_data_d;
            sample_ch_q    <= sample_ch_d;
            sample_valid_q <= sample_valid_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign adc_enable   = adc_enable_q;
    assign adc_clear    = adc_clear_q;
    assign ch_sel       = ch_sel_q;
    assign sample_data  = sample_data_q;
    assign sample_ch    = sample_ch_q;
    assign sample_valid = sample_valid_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer: behavioural ADC handler, sample scoreboard,
// immediate-assertion checks.
module tb_adc_scan_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] chan_mask;
    logic       adc_done;
    logic [7:0] adc_data;
    logic       adc_enable;
    logic       adc_clear;
    logic [1:0] ch_sel;
    logic [7:0] sample_data;
    logic [1:0] sample_ch;
    logic       sample_valid;
    logic       busy;
    logic       frame_done;
    logic       timeout_err;

    adc_scan_sequencer #(.NCH(4), .DW(8), .TIMEOUT(300), .CLR_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .chan_mask    (chan_mask),
        .adc_done     (adc_done),
        .adc_data     (adc_data),
        .adc_enable   (adc_enable),
        .adc_clear    (adc_clear),
        .ch_sel       (ch_sel),
        .sample_data  (sample_data),
        .sample_ch    (sample_ch),
        .sample_valid (sample_valid),
        .busy         (busy),
        .frame_done   (frame_done),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [15:0] sb[$];
    int  clr_cnt = 0;
    int  sv_cnt = 0;
    int  fd_cnt = 0;
    int  en_cyc[4] = '{0, 0, 0, 0};
    int  en_rise_cyc = 0;
    int  sv_cyc = 0;
    bit  en_prev = 1'b0;
    int  done_lat = 20;
    bit  noise = 1'b0;
    int  adc_cnt = 0;
    logic [31:0] idle_or = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({adc_enable, adc_clear, ch_sel, sample_data, sample_ch,
                    sample_valid, busy, frame_done, timeout_err});
    endfunction

    // One clock: observe outputs just after the edge, score samples, then update the ADC model.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (adc_clear) clr_cnt++;
        if (adc_enable) begin
            en_cyc[ch_sel]++;
            if (!en_prev) en_rise_cyc = cyc;
        end
        en_prev = adc_enable;
        if (frame_done) fd_cnt++;
        if (sample_valid) begin
            sv_cnt++;
            sv_cyc = cyc;
            chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                chk("sample", 32'({sample_ch, sample_data}), 32'(sb.pop_front()));
            end
        end
        if (adc_enable && done_lat != 0) begin
            adc_cnt++;
            adc_done = (adc_cnt == done_lat);
        end else begin
            adc_cnt  = 0;
            adc_done = noise ? cyc[0] : 1'b0;
        end
        adc_data = 8'h10 + 8'(ch_sel);
    endtask

    task automatic push_frame(input logic [3:0] m, input int lat);
        for (int c = 0; c < 4; c++) begin
            if (m[c]) sb.push_back(16'((c << 8) | ((lat == 0) ? 8'hFF : (8'h10 + c))));
        end
    endtask

    task automatic start_frame(input logic [3:0] m);
        chan_mask = m;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_frame(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (frame_done) begin
                seen = 1'b1;
                chk("busy_at_frame_done", 32'(busy), 32'd1);
            end
        end
        chk("frame_done_seen", 32'(seen), 32'd1);
    endtask

    int clr0, sv0, fd0;
    int en0[4];

    task automatic snap();
        clr0 = clr_cnt;
        sv0  = sv_cnt;
        fd0  = fd_cnt;
        for (int c = 0; c < 4; c++) en0[c] = en_cyc[c];
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; chan_mask = '0; adc_done = 1'b0; adc_data = '0;

        // Reset then idle, with adc_done toggling
        tick(); tick();
        chk("reset_outputs", all_outs(), 32'd0);
        reset = 1'b1;
        noise = 1'b1;
        snap();
        for (int i = 0; i < 10; i++) begin
            tick();
            idle_or |= all_outs();
        end
        noise = 1'b0;
        adc_done = 1'b0;
        chk("idle_outputs", idle_or, 32'd0);
        chk("idle_samples", 32'(sv_cnt - sv0), 32'd0);

        // Full scan, mask 1111
        done_lat = 20;
        snap();
        push_frame(4'b1111, 20);
        start_frame(4'b1111);
        chk("t1_clear", 32'({adc_clear, adc_enable, busy}), 32'b101);
        tick();
        chk("t2_clear", 32'({adc_clear, adc_enable}), 32'b10);
        tick();
        chk("t3_enable", 32'({adc_clear, adc_enable, ch_sel}), 32'b0100);
        wait_frame(1000);
        chk("full_clr_cycles", 32'(clr_cnt - clr0), 32'd8);
        chk("full_samples", 32'(sv_cnt - sv0), 32'd4);
        chk("full_en_ch3", 32'(en_cyc[3] - en0[3]), 32'd20);
        chk("full_timeout_err", 32'(timeout_err), 32'd0);
        tick();
        chk("full_after", 32'({busy, frame_done}), 32'd0);
        chk("full_frames", 32'(fd_cnt - fd0), 32'd1);
        chk("full_sb_empty", 32'(sb.size()), 32'd0);

        // Sparse mask 1010 with a start pulse mid-frame
        snap();
        push_frame(4'b1010, 20);
        start_frame(4'b1010);
        for (int i = 0; i < 5; i++) tick();
        chan_mask = 4'b0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("midstart_busy", 32'(busy), 32'd1);
        wait_frame(1000);
        tick();
        chk("sparse_samples", 32'(sv_cnt - sv0), 32'd2);
        chk("sparse_en_ch0", 32'(en_cyc[0] - en0[0]), 32'd0);
        chk("sparse_en_ch2", 32'(en_cyc[2] - en0[2]), 32'd0);
        chk("sparse_en_ch1", 32'(en_cyc[1] - en0[1]), 32'd20);
        chk("sparse_frames", 32'(fd_cnt - fd0), 32'd1);
        chk("sparse_sb_empty", 32'(sb.size()), 32'd0);

        // Timeout on channel 2
        done_lat = 0;
        snap();
        push_frame(4'b0100, 0);
        start_frame(4'b0100);
        wait_frame(400);
        chk("to_latency", 32'(sv_cyc - en_rise_cyc), 32'd300);
        chk("to_err_at_done", 32'(timeout_err), 32'd1);
        tick();
        chk("to_err_sticky", 32'({timeout_err, busy}), 32'b10);
        chk("to_sb_empty", 32'(sb.size()), 32'd0);

        // Empty mask: frame_done next cycle, error cleared by the accepted start
        snap();
        start_frame(4'b0000);
        chk("m0_done", 32'({frame_done, busy, timeout_err}), 32'b110);
        tick();
        chk("m0_after", 32'({frame_done, busy}), 32'd0);
        chk("m0_samples", 32'(sv_cnt - sv0), 32'd0);
        chk("m0_no_clear", 32'(clr_cnt - clr0), 32'd0);

        // Done exactly on the timeout edge
        done_lat = 300;
        snap();
        push_frame(4'b0001, 300);
        start_frame(4'b0001);
        wait_frame(400);
        chk("edge_latency", 32'(sv_cyc - en_rise_cyc), 32'd300);
        chk("edge_no_err", 32'(timeout_err), 32'd0);
        chk("edge_sb_empty", 32'(sb.size()), 32'd0);
        tick();

        // Reset during channel 1 conversion, then a fresh scan
        done_lat = 20;
        begin
            bit found = 1'b0;
            push_frame(4'b1111, 20);
            start_frame(4'b1111);
            for (int i = 0; i < 200 && !found; i++) begin
                tick();
                if (adc_enable && ch_sel == 2'd1) found = 1'b1;
            end
            chk("reached_ch1", 32'(found), 32'd1);
        end
        reset = 1'b0;
        tick();
        chk("abort_outputs", all_outs(), 32'd0);
        reset = 1'b1;
        sb.delete();
        snap();
        for (int i = 0; i < 5; i++) tick();
        chk("abort_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
        chk("abort_no_samples", 32'(sv_cnt - sv0), 32'd0);
        push_frame(4'b1111, 20);
        start_frame(4'b1111);
        tick(); tick();
        chk("restart_ch0", 32'({adc_enable, ch_sel}), 32'b100);
        wait_frame(1000);
        chk("restart_samples", 32'(sv_cnt - sv0), 32'd4);
        chk("restart_sb_empty", 32'(sb.size()), 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Sequences one shared single-slope ADC handler (enable/finished/8-bit count interface) across NCH analog channels in a masked round-robin frame scan.
- Per channel: clears the handler, enables it, waits for its finished flag or a timeout, captures the count, advances to the next enabled channel.
- Sits between the frame-level control logic and the ADC handler. Delivers tagged samples with a one-cycle valid strobe.

Parameters:
- NCH, 4, number of channels scanned per frame (2..16).
- DW, 8, ADC result width.
- TIMEOUT, 300, max CONVERT cycles before the conversion is abandoned (must exceed 2^DW).
- CLR_CYCLES, 2, cycles adc_clear is held before each conversion (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  frame trigger, accepted only in IDLE
- chan_mask  in  NCH  channel enable bits, latched on accepted start
- adc_done  in  1  ADC handler finished flag
- adc_data  in  DW  ADC handler count output
- adc_enable  out  1  enable to ADC handler
- adc_clear  out  1  active-high clear to ADC handler
- ch_sel  out  clog2(NCH)  analog mux select, current channel
- sample_data  out  DW  captured result
- sample_ch  out  clog2(NCH)  channel of sample_data
- sample_valid  out  1  one-cycle strobe, sample_data/sample_ch valid
- busy  out  1  high from accepted start until frame_done cycle inclusive
- frame_done  out  1  one-cycle strobe at end of frame
- timeout_err  out  1  sticky, a conversion in this frame timed out

Behaviour:
- Reset (reset=0 at an edge): state IDLE; all outputs 0; internal mask, timer and counters cleared. Reset mid-frame aborts immediately; no sample_valid or frame_done is emitted for the aborted frame.
- States: IDLE, CLEAR, CONVERT, DONE. All outputs are registered.
- IDLE:
  - start=1 at an edge latches chan_mask and clears timeout_err.
  - Latched mask==0 -> DONE next.
  - Otherwise ch_sel <= lowest set bit and the state goes to CLEAR.
  - start while busy is ignored.
- CLEAR: adc_clear=1, adc_enable=0 for exactly CLR_CYCLES cycles, then CONVERT with timer=0.
- CONVERT:
  - adc_enable=1; timer increments each cycle.
  - adc_done is sampled only in CONVERT; it is ignored in every other state.
  - Capture edge, done path: at an edge with adc_done=1, sample_data <= adc_data and sample_ch <= ch_sel.
  - Capture edge, timeout path: at the edge where the timer reaches TIMEOUT-1 with adc_done=0, sample_data <= all ones, sample_ch <= ch_sel, timeout_err <= 1.
  - If adc_done=1 on the timeout edge, done wins: real data is captured and no error is flagged.
  - After either capture: sample_valid=1 for the following cycle only, and adc_enable=0 from that cycle.
  - Next state: if a higher set mask bit exists, ch_sel <= it and state goes to CLEAR (adc_clear asserted in the same cycle as sample_valid). Otherwise state goes to DONE.
- DONE: frame_done=1 and busy=1 for one cycle, then IDLE with busy=0. A start arriving in the DONE cycle is ignored.
- Latency, start edge at t0, first channel:
  - adc_clear high for cycles t0+1 .. t0+CLR_CYCLES.
  - adc_enable high from t0+CLR_CYCLES+1.
  - A done sampled at edge tN gives sample_valid in cycle tN+1.
- No wrap within a frame: each set channel is converted exactly once, in ascending order.
- timeout_err holds until the next accepted start or reset.
- adc_data is sampled only on a capture edge.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release, keep start=0 for 10 cycles -> all outputs 0 throughout; adc_done pulses in this window are ignored.
- Full scan: mask=4'b1111, ADC model asserts done after 20 enable cycles with data 8'h10+ch -> four sample_valid pulses with (ch,data) = (0,10),(1,11),(2,12),(3,13); adc_clear high 2 cycles before each enable; frame_done once; busy then drops.
- Sparse mask: mask=4'b1010 -> only ch 1 and ch 3 are converted; ch_sel never shows 0 or 2 during CONVERT; exactly 2 samples, then frame_done.
- Timeout: mask=4'b0100, done never asserted -> sample_valid 300 cycles after enable rises with data 8'hFF, ch 2; timeout_err=1 and stays 1 after frame_done; the next start clears it.
- Corner cases:
  - mask=0 -> frame_done one cycle after start with no samples.
  - done on the timeout edge -> real data captured, timeout_err stays 0.
  - start pulsed mid-frame -> ignored, no restart.
- Mid-frame reset: reset=0 during ch 1 CONVERT -> next cycle adc_enable=0 and busy=0; no frame_done; a fresh start then scans from the lowest channel.
